// File: rtl/css_mcu0_dmi_router.sv
// Routes one upstream DMI request at a time to one of NUM_TGT address-decoded targets.
// Latency: target strobe 1 cycle after dmi_en; read response (dmi_rvalid) 2+RD_LAT cycles after dmi_en.
// Backpressure: none; dmi_busy is high while an access is in flight and a dmi_en seen then is dropped and flagged in err_sticky.
//
// Ports:
//   clk, rst_l                               clock, asynchronous active-low reset
//   dmi_en/dmi_wr_en/dmi_addr/dmi_wdata      upstream request (single-cycle)
//   dmi_rdata/dmi_rvalid/dmi_busy            upstream read response and in-flight indication
//   tgt_enable                               per-target access enable, sampled in the dmi_en cycle
//   tgt_en/tgt_wr_en/tgt_addr/tgt_wdata      one-hot strobes and shared registered address/data to targets
//   tgt_rdata                                packed per-target read data
//   err_clr/err_sticky                       sticky error flag (denied or dropped access) and its clear
module css_mcu0_dmi_router #(
    parameter int                          NUM_TGT   = 2,
    parameter int                          ADDR_W    = 7,
    parameter int                          DATA_W    = 32,
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE  = {7'h50, 7'h00},
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_LIMIT = {7'h7F, 7'h4F},
    parameter int                          RD_LAT    = 1,
    parameter logic [DATA_W-1:0]           ERR_RDATA = 32'hDEAD_0000
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic [NUM_TGT-1:0]          tgt_enable,
    input  logic                        dmi_en,
    input  logic                        dmi_wr_en,
    input  logic [ADDR_W-1:0]           dmi_addr,
    input  logic [DATA_W-1:0]           dmi_wdata,
    output logic [DATA_W-1:0]           dmi_rdata,
    output logic                        dmi_rvalid,
    output logic                        dmi_busy,
    output logic [NUM_TGT-1:0]          tgt_en,
    output logic [NUM_TGT-1:0]          tgt_wr_en,
    output logic [ADDR_W-1:0]           tgt_addr,
    output logic [DATA_W-1:0]           tgt_wdata,
    input  logic [NUM_TGT*DATA_W-1:0]   tgt_rdata,
    input  logic                        err_clr,
    output logic                        err_sticky
);

    localparam int         SEL_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    // Counter preload for the WAIT state; unused when RD_LAT is 0.
    localparam logic [3:0] LAT_M1 = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, dec_sel;
    logic                wr_q, deny_q;
    logic                dec_hit, dec_deny;
    logic [NUM_TGT-1:0]  tgt_en_q, tgt_en_d, tgt_wr_q, tgt_wr_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q, rdata_d, cap_data;
    logic                err_q, err_d, err_set;
    logic                accept;

    // Address decode: scanning from the top index down lets the lowest
    // matching index overwrite any higher one, so it wins on overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (dmi_addr >= TGT_BASE[i*ADDR_W +: ADDR_W] &&
                dmi_addr <= TGT_LIMIT[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
        dec_deny = !dec_hit || !tgt_enable[dec_sel];
    end

    assign accept   = (state_q == IDLE) && dmi_en;
    // Denied reads return a fixed pattern instead of target data.
    assign cap_data = deny_q ? ERR_RDATA : tgt_rdata[int'(sel_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_en_d = '0;
        tgt_wr_d = '0;
        rdata_d  = rdata_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmi_en) begin
                    state_d = ISSUE;
                    // Strobes are registered so they appear in the ISSUE cycle.
                    if (!dec_deny) begin
                        tgt_en_d[dec_sel] = 1'b1;
                        tgt_wr_d[dec_sel] = dmi_wr_en;
                    end
                end
            end
            ISSUE: begin
                err_set = deny_q;
                if (wr_q) begin
                    state_d = IDLE;
                end else if (RD_LAT == 0) begin
                    rdata_d = cap_data;
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = cap_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A request arriving while busy is dropped, but flagged.
        if (dmi_en && state_q != IDLE) begin
            err_set = 1'b1;
        end
        // Setting takes priority over a simultaneous clear.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tgt_en_q <= '0;
            tgt_wr_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_en_q <= tgt_en_d;
            tgt_wr_q <= tgt_wr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Request capture; the decode result is frozen here so later changes to
    // tgt_enable cannot affect an access already in flight.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            deny_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= dmi_addr;
            wdata_q <= dmi_wdata;
            wr_q    <= dmi_wr_en;
            sel_q   <= dec_sel;
            deny_q  <= dec_deny;
        end
    end

    assign dmi_rdata  = rdata_q;
    assign dmi_rvalid = (state_q == RESP);
    assign dmi_busy   = (state_q != IDLE);
    assign tgt_en     = tgt_en_q;
    assign tgt_wr_en  = tgt_wr_q;
    assign tgt_addr   = addr_q;
    assign tgt_wdata  = wdata_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_css_mcu0_dmi_router.sv
// Bench for css_mcu0_dmi_router: three builds (RD_LAT=1 default map, RD_LAT=0 default map,
// RD_LAT=3 with overlapping apertures) share stimulus buses but have separate dmi_en.
// Expected strobes and responses are queued per build and checked by a negedge monitor.
module tb_css_mcu0_dmi_router;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  en;
        logic [1:0]  wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } stb_t;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst_l;
    logic [1:0]  tgt_enable;
    logic [2:0]  dmi_en;
    logic        dmi_wr_en;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [63:0] tgt_rdata;
    logic        err_clr;

    logic [31:0] o_rdata  [3];
    logic        o_rvalid [3];
    logic        o_busy   [3];
    logic [1:0]  o_en     [3];
    logic [1:0]  o_wr     [3];
    logic [6:0]  o_addr   [3];
    logic [31:0] o_wdata  [3];
    logic        o_err    [3];

    stb_t        stb_q [3][$];
    rsp_t        rsp_q [3][$];

    int unsigned cyc;
    int          n_tests;
    int          n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          LAT   = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam logic [13:0] BASE  = (g == 2) ? {7'h10, 7'h00} : {7'h50, 7'h00};
        localparam logic [13:0] LIMIT = (g == 2) ? {7'h7F, 7'h2F} : {7'h7F, 7'h4F};
        css_mcu0_dmi_router #(
            .NUM_TGT   (2),
            .ADDR_W    (7),
            .DATA_W    (32),
            .TGT_BASE  (BASE),
            .TGT_LIMIT (LIMIT),
            .RD_LAT    (LAT),
            .ERR_RDATA (32'hDEAD_0000)
        ) u_dut (
            .clk        (clk),
            .rst_l      (rst_l),
            .tgt_enable (tgt_enable),
            .dmi_en     (dmi_en[g]),
            .dmi_wr_en  (dmi_wr_en),
            .dmi_addr   (dmi_addr),
            .dmi_wdata  (dmi_wdata),
            .dmi_rdata  (o_rdata[g]),
            .dmi_rvalid (o_rvalid[g]),
            .dmi_busy   (o_busy[g]),
            .tgt_en     (o_en[g]),
            .tgt_wr_en  (o_wr[g]),
            .tgt_addr   (o_addr[g]),
            .tgt_wdata  (o_wdata[g]),
            .tgt_rdata  (tgt_rdata),
            .err_clr    (err_clr),
            .err_sticky (o_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at cycle %0d: got 0x%0h, expected 0x%0h", nm, g, cyc, act, exp);
        end
    endtask

    // Monitor: every strobe and every rvalid must match the head of its queue.
    always @(negedge clk) begin
        stb_t es;
        rsp_t er;
        for (int g = 0; g < 3; g++) begin
            if (o_en[g] != 2'b00 || o_wr[g] != 2'b00) begin
                if (stb_q[g].size() == 0) begin
                    chk("unexpected_strobe", g, 64'(o_en[g]), 64'd0);
                end else begin
                    es = stb_q[g].pop_front();
                    chk("stb_cycle", g, 64'(cyc), 64'(es.cyc));
                    chk("tgt_en", g, 64'(o_en[g]), 64'(es.en));
                    chk("tgt_wr_en", g, 64'(o_wr[g]), 64'(es.wr));
                    chk("tgt_addr", g, 64'(o_addr[g]), 64'(es.addr));
                    chk("tgt_wdata", g, 64'(o_wdata[g]), 64'(es.wdata));
                end
            end
            if (o_rvalid[g]) begin
                if (rsp_q[g].size() == 0) begin
                    chk("unexpected_rvalid", g, 64'd1, 64'd0);
                end else begin
                    er = rsp_q[g].pop_front();
                    chk("rvalid_cycle", g, 64'(cyc), 64'(er.cyc));
                    chk("dmi_rdata", g, 64'(o_rdata[g]), 64'(er.data));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; drives a one-cycle request and queues its expectations.
    task automatic issue(input int g, input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                         input logic exp_stb, input logic [1:0] mask,
                         input logic exp_rsp, input logic [31:0] rdat, input int lat);
        stb_t s;
        rsp_t r;
        dmi_en[g] = 1'b1;
        dmi_wr_en = wr;
        dmi_addr  = addr;
        dmi_wdata = wd;
        if (exp_stb) begin
            s.cyc   = cyc + 1;
            s.en    = mask;
            s.wr    = wr ? mask : 2'b00;
            s.addr  = addr;
            s.wdata = wd;
            stb_q[g].push_back(s);
        end
        if (exp_rsp) begin
            r.cyc  = cyc + 2 + lat;
            r.data = rdat;
            rsp_q[g].push_back(r);
        end
        @(posedge clk);
        #1;
        dmi_en[g] = 1'b0;
    endtask

    task automatic chk_zero(input string nm, input int g);
        chk({nm, "_tgt_en"},    g, 64'(o_en[g]),     64'd0);
        chk({nm, "_tgt_wr_en"}, g, 64'(o_wr[g]),     64'd0);
        chk({nm, "_tgt_addr"},  g, 64'(o_addr[g]),   64'd0);
        chk({nm, "_tgt_wdata"}, g, 64'(o_wdata[g]),  64'd0);
        chk({nm, "_dmi_rdata"}, g, 64'(o_rdata[g]),  64'd0);
        chk({nm, "_rvalid"},    g, 64'(o_rvalid[g]), 64'd0);
        chk({nm, "_busy"},      g, 64'(o_busy[g]),   64'd0);
        chk({nm, "_err"},       g, 64'(o_err[g]),    64'd0);
    endtask

    initial begin
        stb_t s;
        rsp_t r;
        n_tests    = 0;
        n_fail     = 0;
        rst_l      = 1'b0;
        dmi_en     = 3'b000;
        dmi_wr_en  = 1'b0;
        dmi_addr   = 7'h00;
        dmi_wdata  = 32'h0;
        tgt_enable = 2'b11;
        err_clr    = 1'b0;
        tgt_rdata  = {32'h8765_4321, 32'h1234_5678};

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) chk_zero("reset", g);
        rst_l = 1'b1;
        idle(2);

        // Read target 0: strobe T+1, rvalid T+3.
        issue(0, 1'b0, 7'h10, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1234_5678, 1);
        idle(4);
        chk("err_after_read", 0, 64'(o_err[0]), 64'd0);

        // Write target 1: strobes both 10, no response.
        issue(0, 1'b1, 7'h5A, 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0, 32'h0, 1);
        idle(3);
        chk("err_after_write", 0, 64'(o_err[0]), 64'd0);
        chk("rdata_held", 0, 64'(o_rdata[0]), 64'h1234_5678);

        // Read target 1 while enabled.
        issue(0, 1'b0, 7'h60, 32'h0, 1'b1, 2'b10, 1'b1, 32'h8765_4321, 1);
        idle(4);

        // Denied read: no strobe, error data, sticky set, then cleared.
        tgt_enable = 2'b01;
        issue(0, 1'b0, 7'h60, 32'h0, 1'b0, 2'b00, 1'b1, 32'hDEAD_0000, 1);
        idle(1);
        chk("err_denied_read", 0, 64'(o_err[0]), 64'd1);
        idle(3);
        tgt_enable = 2'b11;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("err_cleared", 0, 64'(o_err[0]), 64'd0);

        // Second dmi_en in the ISSUE cycle, with err_clr in the same cycle.
        s.cyc = cyc + 1; s.en = 2'b01; s.wr = 2'b00; s.addr = 7'h20; s.wdata = 32'h0;
        stb_q[0].push_back(s);
        r.cyc = cyc + 3; r.data = 32'h1234_5678;
        rsp_q[0].push_back(r);
        dmi_en[0] = 1'b1; dmi_wr_en = 1'b0; dmi_addr = 7'h20; dmi_wdata = 32'h0;
        idle(1);
        dmi_wr_en = 1'b1; dmi_addr = 7'h55; dmi_wdata = 32'hFFFF_FFFF; err_clr = 1'b1;
        idle(1);
        dmi_en[0] = 1'b0; err_clr = 1'b0;
        chk("err_busy_req", 0, 64'(o_err[0]), 64'd1);
        idle(3);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("err_cleared2", 0, 64'(o_err[0]), 64'd0);

        // tgt_enable drops after decode: access still completes.
        issue(0, 1'b0, 7'h30, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1234_5678, 1);
        tgt_enable = 2'b00;
        idle(4);
        tgt_enable = 2'b11;
        chk("err_enable_drop", 0, 64'(o_err[0]), 64'd0);

        // Denied write is dropped and flagged.
        tgt_enable = 2'b01;
        issue(0, 1'b1, 7'h70, 32'h1111_2222, 1'b0, 2'b00, 1'b0, 32'h0, 1);
        idle(1);
        chk("err_denied_write", 0, 64'(o_err[0]), 64'd1);
        tgt_enable = 2'b11;
        idle(2);

        // Reset while in WAIT: outputs clear at once, no response afterwards.
        issue(0, 1'b0, 7'h10, 32'h0, 1'b1, 2'b01, 1'b0, 32'h0, 1);
        idle(1);
        chk("busy_in_wait", 0, 64'(o_busy[0]), 64'd1);
        rst_l = 1'b0;
        #1;
        chk_zero("mid_reset", 0);
        idle(2);
        rst_l = 1'b1;
        idle(5);
        issue(0, 1'b0, 7'h00, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1234_5678, 1);
        idle(4);

        // RD_LAT=0 build: rvalid at T+2.
        issue(1, 1'b0, 7'h10, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1234_5678, 0);
        idle(3);
        issue(1, 1'b1, 7'h55, 32'hA5A5_5A5A, 1'b1, 2'b10, 1'b0, 32'h0, 0);
        idle(3);

        // RD_LAT=3 build with overlapping apertures: rvalid at T+5, lowest index wins.
        issue(2, 1'b0, 7'h20, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1234_5678, 3);
        idle(6);
        issue(2, 1'b0, 7'h40, 32'h0, 1'b1, 2'b10, 1'b1, 32'h8765_4321, 3);
        idle(6);

        idle(5);
        for (int g = 0; g < 3; g++) begin
            chk("missing_strobe", g, 64'(stb_q[g].size()), 64'd0);
            chk("missing_rvalid", g, 64'(rsp_q[g].size()), 64'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
